// File: rtl/seg7_capture_decoder.sv
// Glitch-filtering 7-segment capture and decoder with a valid/ready result port.
// Optional macro SEG7_DEC_ERRCNT_EN builds the saturating illegal-pattern counter.
module seg7_capture_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       segments_in,
  input  logic             none_in,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [2:0]       out_code,
  output logic [7:0]       out_onehot,
  output logic             out_none,
  output logic             err_invalid,
  output logic             overflow,
  output logic [CNT_W-1:0] err_count
);

  // Handshake: a result transfers on any edge where out_valid && out_ready;
  // while out_valid is high, out_code/out_onehot/out_none stay stable.

  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic {ST_EMPTY, ST_FULL} state_t;

  logic [7:0]       r_s_q;
  logic [7:0]       r_cand;
  logic [CNT_W-1:0] r_cnt;
  logic             r_armed;
  logic [7:0]       r_last;
  logic             r_last_vld;
  logic             r_err;
  logic             r_ovf;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [2:0]       r_out_code;
  logic [7:0]       r_out_onehot;
  logic             r_out_none;
  logic [2:0]       r_pend_code;
  logic [7:0]       r_pend_onehot;
  logic             r_pend_none;
  logic             r_pend_vld;

  logic             w_accept;
  logic             w_legal;
  logic [2:0]       w_code;
  logic             w_none;
  logic [7:0]       w_onehot;
  logic             w_emit;
  logic             w_out_new;
  logic             w_out_pend;
  logic             w_pend_load;
  logic             w_pend_clr;
  logic             w_ovf_set;

  // r_armed keeps the reset value of cand from being treated as a real run.
  assign w_accept = r_armed && (r_cnt == CNT_LAST) &&
                    !(r_last_vld && (r_last == r_cand));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s_q      <= '0;
      r_cand     <= '0;
      r_cnt      <= '0;
      r_armed    <= 1'b0;
      r_last     <= '0;
      r_last_vld <= 1'b0;
    end else begin
      r_s_q <= {none_in, segments_in};
      if (r_s_q != r_cand) begin
        r_cand  <= r_s_q;
        r_cnt   <= '0;
        r_armed <= 1'b1;
      end else begin
        if (r_cnt != CNT_SAT) r_cnt <= r_cnt + CNT_W'(1);
        if (w_accept) r_armed <= 1'b0;
      end
      if (w_accept) begin
        r_last     <= r_cand;
        r_last_vld <= 1'b1;
      end
    end
  end

  always_comb begin
    w_legal = 1'b1;
    w_code  = 3'd0;
    w_none  = 1'b0;
    case (r_cand)
      8'b0_0111111: w_code = 3'd0;
      8'b0_0000110: w_code = 3'd1;
      8'b0_1011011: w_code = 3'd2;
      8'b0_1001111: w_code = 3'd3;
      8'b0_1100110: w_code = 3'd4;
      8'b0_1101101: w_code = 3'd5;
      8'b0_1111101: w_code = 3'd6;
      8'b0_0000111: w_code = 3'd7;
      8'b1_0000000: w_none = 1'b1;
      default:      w_legal = 1'b0;
    endcase
  end

  assign w_onehot = w_none ? 8'h00 : (8'h01 << w_code);
  assign w_emit   = w_accept && w_legal;

  always_comb begin
    w_state_nxt = r_state;
    w_out_new   = 1'b0;
    w_out_pend  = 1'b0;
    w_pend_load = 1'b0;
    w_pend_clr  = 1'b0;
    w_ovf_set   = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_emit) begin
          w_out_new   = 1'b1;
          w_state_nxt = ST_FULL;
        end
      end
      ST_FULL: begin
        if (out_ready) begin
          if (r_pend_vld) begin
            w_out_pend  = 1'b1;
            w_pend_load = w_emit;
            w_pend_clr  = !w_emit;
          end else if (w_emit) begin
            w_out_new = 1'b1;
          end else begin
            w_state_nxt = ST_EMPTY;
          end
        end else if (w_emit) begin
          w_pend_load = 1'b1;
          w_ovf_set   = r_pend_vld;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_EMPTY;
      r_out_code    <= '0;
      r_out_onehot  <= '0;
      r_out_none    <= 1'b0;
      r_pend_code   <= '0;
      r_pend_onehot <= '0;
      r_pend_none   <= 1'b0;
      r_pend_vld    <= 1'b0;
      r_ovf         <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= w_accept && !w_legal;
      if (w_ovf_set) r_ovf <= 1'b1;
      if (w_out_new) begin
        r_out_code   <= w_code;
        r_out_onehot <= w_onehot;
        r_out_none   <= w_none;
      end else if (w_out_pend) begin
        r_out_code   <= r_pend_code;
        r_out_onehot <= r_pend_onehot;
        r_out_none   <= r_pend_none;
      end
      if (w_pend_load) begin
        r_pend_code   <= w_code;
        r_pend_onehot <= w_onehot;
        r_pend_none   <= w_none;
        r_pend_vld    <= 1'b1;
      end else if (w_pend_clr) begin
        r_pend_vld <= 1'b0;
      end
    end
  end

`ifdef SEG7_DEC_ERRCNT_EN
  logic [CNT_W-1:0] r_err_cnt;
  always_ff @(posedge clk) begin
    if (rst) r_err_cnt <= '0;
    else if (w_accept && !w_legal && (r_err_cnt != {CNT_W{1'b1}}))
      r_err_cnt <= r_err_cnt + CNT_W'(1);
  end
  assign err_count = r_err_cnt;
`else
  assign err_count = '0;
`endif

  assign out_valid   = (r_state == ST_FULL);
  assign out_code    = r_out_code;
  assign out_onehot  = r_out_onehot;
  assign out_none    = r_out_none;
  assign err_invalid = r_err;
  assign overflow    = r_ovf;

endmodule

// File: tb/tb_seg7_capture_decoder.sv
// Randomized and directed bench for seg7_capture_decoder with a queue-based
// reference model of the filter and of the two-deep result slot.
module tb_seg7_capture_decoder;

  localparam int STABLE = 4;
  localparam int CNT_W  = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [6:0]       segments_in;
  logic             none_in;
  logic             out_ready;
  logic             out_valid;
  logic [2:0]       out_code;
  logic [7:0]       out_onehot;
  logic             out_none;
  logic             err_invalid;
  logic             overflow;
  logic [CNT_W-1:0] err_count;

  seg7_capture_decoder #(.STABLE_CYCLES(STABLE), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .segments_in(segments_in), .none_in(none_in),
    .out_ready(out_ready), .out_valid(out_valid), .out_code(out_code),
    .out_onehot(out_onehot), .out_none(out_none), .err_invalid(err_invalid),
    .overflow(overflow), .err_count(err_count)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [6:0] seg_tab [8] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                              7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111};
  localparam logic [7:0] NONE_PAT = 8'b1_0000000;

  int         total = 0;
  int         bad   = 0;
  logic [3:0] exp_q [$];   // {none, code} in consumption order
  logic [3:0] m_slot[$];   // results the DUT should be holding (output, pending)
  logic [7:0] m_prev;
  int         m_len;
  logic [7:0] m_last;
  logic       m_last_vld;
  logic       p1_v, p2_v;
  logic [7:0] p1_val, p2_val;
  logic       m_ovf;
  logic       m_err;
  int         m_errcnt;

  function automatic logic [4:0] decode(input logic [7:0] v); // {legal, none, code}
    if (v == NONE_PAT) return 5'b11000;
    for (int i = 0; i < 8; i++)
      if (v == {1'b0, seg_tab[i]}) return {2'b10, 3'(i)};
    return 5'b00000;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_slot.delete();
    m_prev = 8'h00; m_len = 0; m_last = 8'h00; m_last_vld = 1'b0;
    p1_v = 1'b0; p2_v = 1'b0; p1_val = 8'h00; p2_val = 8'h00;
    m_ovf = 1'b0; m_err = 1'b0; m_errcnt = 0;
  endtask

  // One call per rising edge, using the inputs the DUT sampled on that edge.
  task automatic model_step();
    logic [7:0] s;
    logic [4:0] d;
    logic       hit;
    if (rst) begin
      model_reset();
      return;
    end
    if (m_slot.size() > 0 && out_ready) exp_q.push_back(m_slot.pop_front());
    m_err = 1'b0;
    if (p2_v) begin
      d = decode(p2_val);
      if (d[4]) begin
        m_slot.push_back(d[3:0]);
        if (m_slot.size() > 2) begin
          m_slot.delete(1);
          m_ovf = 1'b1;
        end
      end else begin
        m_err = 1'b1;
        if (m_errcnt < 255) m_errcnt++;
      end
    end
    p2_v = p1_v; p2_val = p1_val;
    s   = {none_in, segments_in};
    hit = 1'b0;
    if (s != m_prev) begin
      m_prev = s;
      m_len  = 1;
      hit    = (m_len == STABLE);
    end else if (m_len > 0 && m_len < STABLE) begin
      m_len++;
      hit = (m_len == STABLE);
    end
    p1_v = 1'b0; p1_val = s;
    if (hit && !(m_last_vld && s == m_last)) begin
      p1_v       = 1'b1;
      m_last     = s;
      m_last_vld = 1'b1;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_in(input logic [7:0] v);
    {none_in, segments_in} = v;
  endtask

  function automatic logic [7:0] pat(input int i);
    return {1'b0, seg_tab[i]};
  endfunction

  task automatic hold(input logic [7:0] v, input int n);
    set_in(v);
    repeat (n) tick();
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic       hs;
  logic [3:0] act;
  logic [3:0] exp_item;
  int         exp_errcnt;

  initial begin
    forever begin
      @(negedge clk);
`ifdef SEG7_DEC_ERRCNT_EN
      exp_errcnt = m_errcnt;
`else
      exp_errcnt = 0;
`endif
      check("out_valid", int'(out_valid), int'(m_slot.size() > 0));
      check("overflow", int'(overflow), int'(m_ovf));
      check("err_invalid", int'(err_invalid), int'(m_err));
      check("err_count", int'(err_count), exp_errcnt);
      hs  = !rst && out_valid && out_ready;
      act = {out_none, out_code};
      if (hs)
        check("out_onehot", int'(out_onehot),
              out_none ? 0 : int'(8'h01 << out_code));
      @(posedge clk);
      #2;
      if (hs) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", int'(act), -1);
        end else begin
          exp_item = exp_q.pop_front();
          check("result_none_code", int'(act), int'(exp_item));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  int n;
  int kind;
  int len;

  initial begin
    model_reset();
    rst = 1'b1; out_ready = 1'b0; set_in(8'h00);
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();
    check("reset_valid", int'(out_valid), 0);
    check("reset_onehot", int'(out_onehot), 0);

    // latency for a fresh legal pattern with an empty output slot
    set_in(pat(2));
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check("latency_edges", n, STABLE + 2);
    check("p2_code", int'(out_code), 2);
    check("p2_onehot", int'(out_onehot), 8'h04);
    check("p2_none", int'(out_none), 0);
    out_ready = 1'b1; tick();
    out_ready = 1'b0; tick();
    check("p2_drained", int'(out_valid), 0);

    // glitching input must not produce results
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) hold((i % 2 == 0) ? pat(7) : pat(1), 2);
    hold(pat(7), 10);

    // no-data pattern then an illegal one
    out_ready = 1'b0;
    hold(NONE_PAT, 8);
    check("none_flag", int'(out_none), 1);
    check("none_onehot", int'(out_onehot), 0);
    out_ready = 1'b1; tick();
    hold({1'b1, seg_tab[1]}, 10);

    // overwrite of the pending slot while the consumer stalls
    out_ready = 1'b0;
    hold(pat(3), 8);
    hold(pat(5), 8);
    hold(pat(6), 8);
    check("stall_code", int'(out_code), 3);
    check("stall_ovf", int'(overflow), 1);
    out_ready = 1'b1; tick();
    out_ready = 1'b0; tick();
    check("second_code", int'(out_code), 6);
    out_ready = 1'b1; tick();

    // long hold emits once; a change and return emits again
    hold(pat(4), 50);
    hold(pat(5), 8);
    hold(pat(4), 8);

    // reset while a result and a pending result are held
    out_ready = 1'b0;
    hold(pat(1), 8);
    hold(pat(0), 8);
    check("pre_reset_valid", int'(out_valid), 1);
    rst = 1'b1; tick();
    check("post_reset_valid", int'(out_valid), 0);
    check("post_reset_ovf", int'(overflow), 0);
    check("post_reset_errcnt", int'(err_count), 0);
    rst = 1'b0;
    hold(8'h00, 12);

    // randomized patterns, glitches and back-pressure
    for (int s = 0; s < 300; s++) begin
      kind = $urandom_range(0, 9);
      if (kind < 7)       set_in(pat($urandom_range(0, 7)));
      else if (kind == 7) set_in(NONE_PAT);
      else                set_in(8'($urandom));
      len = $urandom_range(1, 8);
      for (int c = 0; c < len; c++) begin
        out_ready = ($urandom_range(0, 2) != 0);
        tick();
      end
    end

    out_ready = 1'b1;
    repeat (20) tick();
    @(negedge clk);
    @(negedge clk);
    check("exp_q_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
